// File: rtl/led_dimmer_ctrl_pkg.sv
// Shared types and defaults for the bright_led dimmer: FSM state encoding,
// default PWM width and a helper that sizes the hold/repeat timer.
package led_dimmer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int PWM_W_DEF = 8;

  // Timer only ever holds values up to max-1; keep at least one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/led_dimmer_ctrl_pwm_gen.sv
// Glitch-free PWM: free-running counter, duty shadowed at the period end,
// registered compare output aligned to the period start.
module led_dimmer_ctrl_pwm_gen
  import led_dimmer_ctrl_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             led
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty_active;
  logic             r_led;
  logic [PWM_W-1:0] w_cnt_nxt;
  logic [PWM_W-1:0] w_active_nxt;

  // Shadow only on the last count so a mid-period change waits for cnt=0.
  assign w_cnt_nxt    = r_cnt + PWM_W'(1);
  assign w_active_nxt = (r_cnt == CNT_MAX) ? duty : r_duty_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_duty_active <= '0;
      r_led         <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_duty_active <= w_active_nxt;
      r_led         <= (w_cnt_nxt < w_active_nxt);
    end
  end

  assign led = r_led;

endmodule

// File: rtl/led_dimmer_ctrl.sv
// Button-to-brightness controller: one step per press, auto-repeat while held,
// stepping duty of an embedded PWM; step_pulse marks each duty change.
module led_dimmer_ctrl
  import led_dimmer_ctrl_pkg::*;
#(
  parameter int PWM_W         = PWM_W_DEF,
  parameter int STEP          = 32,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_in,
  output logic             led,
  output logic [PWM_W-1:0] duty,
  output logic             step_pulse
);

  localparam int               TMR_W      = tmr_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST   = TMR_W'(REPEAT_CYCLES - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_W:0]   DUTY_MAX_X = {1'b0, DUTY_MAX};
  localparam logic [PWM_W:0]   STEP_X     = (PWM_W + 1)'(STEP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [PWM_W-1:0] r_duty;
  logic             r_step_pulse;
  logic             w_step;
  logic [PWM_W:0]   w_sum;
  logic [PWM_W-1:0] w_duty_step;

  // Extra sum bit catches overflow so saturation is explicit.
  assign w_sum = {1'b0, r_duty} + STEP_X;

  always_comb begin
    w_duty_step = w_sum[PWM_W-1:0];
    if (r_duty == DUTY_MAX) begin
      w_duty_step = '0;
    end else if (w_sum > DUTY_MAX_X) begin
      w_duty_step = DUTY_MAX;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (button_in) begin
          w_step      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!button_in) begin
          w_state_nxt = IDLE;
        end else if (r_timer == HOLD_LAST) begin
          w_state_nxt = REPEAT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      REPEAT: begin
        // Release wins over a simultaneous timer expiry.
        if (!button_in) begin
          w_state_nxt = IDLE;
        end else if (r_timer == REP_LAST) begin
          w_step = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_duty       <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_step_pulse <= w_step;
      if (w_step) begin
        r_duty <= w_duty_step;
      end
    end
  end

  led_dimmer_ctrl_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm_gen (
    .clk  (clk),
    .rst  (rst),
    .duty (r_duty),
    .led  (led)
  );

  assign duty       = r_duty;
  assign step_pulse = r_step_pulse;

endmodule
